// File: rtl/pattern_loader_pkg.sv
// ============================================================================
// pattern_loader_pkg
//   Shared state encoding, link defaults and frame-select levels.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package pattern_loader_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_GAP_CYC = 2;

  localparam logic SSEL_ACTIVE = 1'b0;
  localparam logic SSEL_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pattern_loader_serial_shifter.sv
// ============================================================================
// pattern_loader_serial_shifter
//   Parallel-load MSB-first shift-out with simultaneous shift-in and bit count.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module pattern_loader_serial_shifter
  import pattern_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  input  logic              ser_in,
  output logic              tx_msb,
  output logic              next_bit,
  output logic              last_bit,
  output logic [DATA_W-1:0] rx_word
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [CNT_W-1:0]  bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (load) begin
      tx_shift <= load_data;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (shift_en) begin
      tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      rx_shift <= {rx_shift[DATA_W-2:0], ser_in};
      if (bit_cnt != FULL_CNT) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // next_bit is the bit that goes on the wire once the current one is shifted away
  assign tx_msb   = tx_shift[DATA_W-1];
  assign next_bit = tx_shift[DATA_W-2];
  assign last_bit = (bit_cnt == LAST_CNT);
  assign rx_word  = rx_shift;

endmodule

`default_nettype wire

// File: rtl/pattern_loader.sv
// ============================================================================
// pattern_loader
//   Frames (address, byte) writes onto ssel/saddr/sin and captures sout readback.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module pattern_loader
  import pattern_loader_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              sin,
  output logic              ssel,
  output logic [ADDR_W-1:0] saddr,
  input  logic              sout,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t            state, state_nxt;
  logic [3:0]        gap_cnt, gap_nxt;
  logic              ssel_nxt, sin_nxt, rd_valid_nxt;
  logic [ADDR_W-1:0] saddr_nxt;
  logic [DATA_W-1:0] rd_data_nxt;
  logic              load, shift_en;
  logic              tx_msb, next_bit, last_bit;
  logic [DATA_W-1:0] rx_word;

  pattern_loader_serial_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk       (sclk),
    .rst       (rst),
    .load      (load),
    .load_data (wr_data),
    .shift_en  (shift_en),
    .ser_in    (sout),
    .tx_msb    (tx_msb),
    .next_bit  (next_bit),
    .last_bit  (last_bit),
    .rx_word   (rx_word)
  );

  // ssel drops on the accept edge so SETUP already counts toward the frame
  always_comb begin
    state_nxt    = state;
    gap_nxt      = gap_cnt;
    ssel_nxt     = ssel;
    sin_nxt      = sin;
    saddr_nxt    = saddr;
    rd_valid_nxt = 1'b0;
    rd_data_nxt  = rd_data;
    load         = 1'b0;
    shift_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_valid && wr_ready) begin
          load      = 1'b1;
          saddr_nxt = wr_addr;
          ssel_nxt  = SSEL_ACTIVE;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        sin_nxt   = tx_msb;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) begin
          state_nxt = ST_HOLD;
        end else begin
          sin_nxt = next_bit;
        end
      end
      ST_HOLD: begin
        ssel_nxt     = SSEL_IDLE;
        sin_nxt      = 1'b0;
        rd_data_nxt  = rx_word;
        rd_valid_nxt = 1'b1;
        gap_nxt      = 4'd0;
        state_nxt    = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_cnt + 4'd1;
        end
      end
      default: begin
        ssel_nxt  = SSEL_IDLE;
        sin_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gap_cnt  <= 4'd0;
      ssel     <= SSEL_IDLE;
      sin      <= 1'b0;
      saddr    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      wr_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      gap_cnt  <= gap_nxt;
      ssel     <= ssel_nxt;
      sin      <= sin_nxt;
      saddr    <= saddr_nxt;
      rd_valid <= rd_valid_nxt;
      rd_data  <= rd_data_nxt;
      wr_ready <= (state_nxt == ST_IDLE);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pattern_loader.sv
// ============================================================================
// tb_pattern_loader
//   Table-driven writes against a bench-side buffer model with a scoreboard.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pattern_loader;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int GAP = 2;

  logic          sclk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          sin;
  logic          ssel;
  logic [AW-1:0] saddr;
  logic          sout = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;

  always #5 sclk = ~sclk;

  pattern_loader #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .GAP_CYC (GAP)
  ) dut (
    .sclk     (sclk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sin      (sin),
    .ssel     (ssel),
    .saddr    (saddr),
    .sout     (sout),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] ret;
    logic [DW-1:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rd;
    int            acc;
  } exp_t;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rd_pulses = 0;

  exp_t          sb_q[$];
  logic [DW-1:0] ret_q[$];
  logic          force_en = 1'b0;
  logic          force_val = 1'b0;
  vec_t          vecs[5];

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Buffer-side model: returns frame_ret MSB first during the shift cycles
  int            low_cnt = 0;
  logic [DW-1:0] frame_ret = '0;
  logic [DW-1:0] sin_word = '0;
  logic [AW-1:0] frame_addr = '0;
  bit            addr_bad = 1'b0;
  exp_t          e;

  always @(negedge sclk) begin
    if (rd_valid) rd_pulses++;
    if (rst) begin
      low_cnt = 0;
      sout = 1'b0;
    end else if (!ssel) begin
      if (low_cnt == 0) begin
        frame_ret  = (ret_q.size() > 0) ? ret_q.pop_front() : '0;
        frame_addr = saddr;
        sin_word   = '0;
        addr_bad   = 1'b0;
      end else if (saddr !== frame_addr) begin
        addr_bad = 1'b1;
      end
      if (rd_valid) check("rd_valid_during_frame", 32'(rd_valid), 32'd0);
      if (low_cnt >= 1 && low_cnt <= DW) begin
        sin_word = {sin_word[DW-2:0], sin};
        sout = force_en ? force_val : frame_ret[DW-low_cnt];
      end else begin
        sout = force_en ? force_val : 1'b0;
      end
      low_cnt++;
    end else begin
      sout = force_en ? force_val : 1'b0;
      if (low_cnt != 0) begin
        check("ssel_low_len", low_cnt, DW + 2);
        check("rd_valid_at_end", 32'(rd_valid), 32'd1);
        check("saddr_stable", 32'(addr_bad), 32'd0);
        if (sb_q.size() == 0) begin
          check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e.rd));
          check("sin_word", 32'(sin_word), 32'(e.data));
          check("frame_addr", 32'(frame_addr), 32'(e.addr));
          check("latency", cyc + 1 - e.acc, DW + 3);
        end
        low_cnt = 0;
      end else if (rd_valid) begin
        check("spurious_rd_valid", 32'(rd_valid), 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] ret, input logic [DW-1:0] rd_exp,
                      input bit hold, output int acc);
    exp_t r;
    int   n;
    n = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && n < 200) begin
      @(negedge sclk);
      n++;
    end
    if (!wr_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      wr_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc + 1;
      r = '{a, d, rd_exp, acc};
      sb_q.push_back(r);
      ret_q.push_back(ret);
      @(negedge sclk);
      if (!hold) wr_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge sclk);
      n++;
    end
    check("drain", sb_q.size(), 0);
    repeat (GAP + 2) @(negedge sclk);
  endtask

  initial begin
    int acc1, acc2, p;
    vecs[0] = '{3'd5, 8'hA5, 8'h3C, 8'h3C};
    vecs[1] = '{3'd0, 8'h00, 8'hFF, 8'hFF};
    vecs[2] = '{3'd7, 8'hFF, 8'h00, 8'h00};
    vecs[3] = '{3'd1, 8'h5A, 8'h81, 8'h81};
    vecs[4] = '{3'd6, 8'h80, 8'h01, 8'h01};

    repeat (3) @(negedge sclk);
    check("reset_values", {ssel, sin, wr_ready, busy, rd_valid, saddr, rd_data},
          {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00});
    rst = 1'b0;
    repeat (10) @(negedge sclk);
    check("idle_10", {ssel, sin, wr_ready, busy, rd_valid}, 5'b10100);
    check("idle_no_rd_valid", rd_pulses, 0);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].addr, vecs[i].data, vecs[i].ret, vecs[i].exp_rd, 1'b0, acc1);
      drain();
    end

    // back-to-back with wr_valid held high
    send(3'd2, 8'h01, 8'h96, 8'h96, 1'b1, acc1);
    check("ready_low_busy_high", {wr_ready, busy}, 2'b01);
    send(3'd6, 8'hFF, 8'h69, 8'h69, 1'b0, acc2);
    check("b2b_spacing", acc2 - acc1, DW + 3 + GAP);
    drain();

    // request changes right after accept
    send(3'd4, 8'hC3, 8'h5A, 8'h5A, 1'b0, acc1);
    wr_addr = 3'd1;
    wr_data = 8'h18;
    drain();

    // reset during the 4th shift cycle
    send(3'd7, 8'h6B, 8'hE7, 8'hE7, 1'b0, acc1);
    repeat (4) @(posedge sclk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {ssel, sin, wr_ready, busy, rd_valid, saddr}, {5'b10100, 3'd0});
    sb_q.delete();
    ret_q.delete();
    p = rd_pulses;
    @(negedge sclk);
    @(negedge sclk);
    rst = 1'b0;
    repeat (15) @(negedge sclk);
    check("no_rd_valid_after_rst", rd_pulses, p);
    send(3'd0, 8'h80, 8'h42, 8'h42, 1'b0, acc1);
    drain();

    // constant sout levels
    force_en  = 1'b1;
    force_val = 1'b1;
    send(3'd3, 8'h33, 8'h00, 8'hFF, 1'b0, acc1);
    drain();
    force_val = 1'b0;
    send(3'd3, 8'hCC, 8'hFF, 8'h00, 1'b0, acc1);
    drain();
    force_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
